mult_arb: RTL and testbench

MULT_ARB -- requirements
Module: mult_arb

---
 rtl/mult_arb_pkg.sv | 10 +
 rtl/mult_arb_mult.sv | 16 +
 rtl/mult_arb.sv | 114 +++++++++++
 tb/tb_mult_arb.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types for the mult_arb arbiter slice.
//   arb_state_e : result-slot state, EMPTY (no product held) / FULL (product held)
package mult_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mult_arb_mult.sv
// mult_NxN: purely combinational unsigned NxN multiplier, full 2N-bit product.
//   a, b : N-bit unsigned operands
//   y    : 2N-bit unsigned product a*b
module mult_NxN #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] y
);

  always_comb begin
    y = {{N{1'b0}}, a} * {{N{1'b0}}, b};
  end

endmodule

// File: rtl/mult_arb.sv
// mult_arb: round-robin arbiter sharing one NxN multiplier among R requesters,
// with a single registered result slot.
//   clk, rst_n : clock, synchronous active-low reset
//   req_valid  : per-requester request valid (R bits)
//   req_a/b    : packed operands, requester r at [r*N +: N]
//   req_ready  : one-hot grant, combinational
//   res_valid  : result slot holds a product
//   res_y      : registered 2N-bit product
//   res_id     : index of the requester owning res_y
//   res_ready  : consumer accepts the result
//   op_count   : saturating count of accepted operations
module mult_arb
  import mult_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int R  = 4,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [R-1:0]         req_valid,
  input  logic [R*N-1:0]       req_a,
  input  logic [R*N-1:0]       req_b,
  output logic [R-1:0]         req_ready,
  output logic                 res_valid,
  output logic [2*N-1:0]       res_y,
  output logic [$clog2(R)-1:0] res_id,
  input  logic                 res_ready,
  output logic [CW-1:0]        op_count
);

  localparam int IDW = $clog2(R);

  arb_state_e     state;
  arb_state_e     state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] ptr_nxt;
  logic           grant_any;
  logic           slot_free;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [2*N-1:0] prod;
  int unsigned    idx;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    slot_free = !res_valid || res_ready;
    if (rst_n && slot_free) begin
      for (int unsigned k = 0; k < R; k++) begin
        idx = int'(ptr) + k;
        if (idx >= R) idx = idx - R;
        if (!grant_any && req_valid[IDW'(idx)]) begin
          grant_any           = 1'b1;
          grant_id            = IDW'(idx);
          req_ready[IDW'(idx)] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    op_a    = req_a[grant_id*N +: N];
    op_b    = req_b[grant_id*N +: N];
    ptr_nxt = (grant_id == IDW'(R - 1)) ? '0 : grant_id + 1'b1;
  end

  mult_NxN #(.N(N)) u_mult (
    .a (op_a),
    .b (op_b),
    .y (prod)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (grant_any) state_nxt = FULL;
      FULL:  if (res_ready && !grant_any) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    res_valid = (state == FULL);
  end

  // Result, owner, pointer and counter; all load only on an accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_y    <= '0;
      res_id   <= '0;
      ptr      <= '0;
      op_count <= '0;
    end else if (grant_any) begin
      res_y  <= prod;
      res_id <= grant_id;
      ptr    <= ptr_nxt;
      if (op_count != '1) op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_arb.sv
module tb_mult_arb;

  localparam int N = 4;
  localparam int R = 4;

  typedef struct {
    int id;
    int y;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [R-1:0]   req_valid;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic           res_ready;

  logic [R-1:0]   req_ready,  req_ready2;
  logic           res_valid,  res_valid2;
  logic [2*N-1:0] res_y,      res_y2;
  logic [1:0]     res_id,     res_id2;
  logic [15:0]    op_count;
  logic [1:0]     op_count2;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        m_valid = 1'b0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  int          m_cnt2 = 0;
  logic [R-1:0] last_rdy;

  always #5 clk = ~clk;

  mult_arb #(.N(N), .R(R), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_y(res_y), .res_id(res_id),
    .res_ready(res_ready), .op_count(op_count)
  );

  mult_arb #(.N(N), .R(R), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready2), .res_valid(res_valid2), .res_y(res_y2), .res_id(res_id2),
    .res_ready(res_ready), .op_count(op_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every drained result must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("res_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_y", 32'(res_y), 32'(e.y));
        chk("res_id", 32'(res_id), 32'(e.id));
      end
    end
  end

  // One clock cycle: inputs already applied; check grant against the
  // reference model at negedge, then advance the model across the edge.
  task automatic step();
    logic [R-1:0] exp_rdy;
    int g;
    int idx;
    int a, b;
    @(negedge clk);
    exp_rdy = '0;
    g = -1;
    if (rst_n && (!m_valid || res_ready)) begin
      for (int k = 0; k < R; k++) begin
        idx = (m_ptr + k) % R;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    last_rdy = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("op_count", 32'(op_count), 32'(m_cnt));
    chk("op_count_cw2", 32'(op_count2), 32'(m_cnt2));
    if (!rst_n) begin
      m_valid = 1'b0; m_ptr = 0; m_cnt = 0; m_cnt2 = 0;
      exp_q.delete();
    end else if (g >= 0) begin
      a = int'(req_a[g*N +: N]);
      b = int'(req_b[g*N +: N]);
      exp_q.push_back('{id: g, y: a * b});
      m_valid = 1'b1;
      m_ptr = (g + 1) % R;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_y[5];
    int exp_c2[5];
    logic [R-1:0] onehot;
    exp_y  = '{6, 20, 42, 72, 6};
    exp_c2 = '{1, 2, 3, 3, 3};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
    @(posedge clk); #1;
    step();
    rst_n = 1'b1;
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_res_y", 32'(res_y), 32'd0);
    chk("reset_res_id", 32'(res_id), 32'd0);
    chk("reset_op_count", 32'(op_count), 32'd0);

    // Requester 2 alone, 15*15
    req_a[2*N +: N] = 4'd15; req_b[2*N +: N] = 4'd15;
    req_valid = 4'b0100; res_ready = 1'b1;
    step();
    chk("single_ready", 32'(last_rdy), 32'b0100);
    chk("single_res_valid", 32'(res_valid), 32'd1);
    chk("single_res_y", 32'(res_y), 32'd225);
    chk("single_res_id", 32'(res_id), 32'd2);
    req_valid = '0;
    step();
    chk("drain_empty", 32'(res_valid), 32'd0);

    // Reset, then all four valid: round-robin 0,1,2,3,0
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int r = 0; r < R; r++) begin
      req_a[r*N +: N] = 4'(2*r + 3);
      req_b[r*N +: N] = 4'(2*r + 2);
    end
    req_valid = 4'b1111; res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      onehot = 4'b0001 << (i % 4);
      chk("rr_grant", 32'(last_rdy), 32'(onehot));
      chk("rr_res_y", 32'(res_y), 32'(exp_y[i]));
      chk("cw2_sat", 32'(op_count2), 32'(exp_c2[i]));
    end
    chk("rr_op_count", 32'(op_count), 32'd5);

    // Back-pressure: held result (id 0, 6) stays put, no grants
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready", 32'(last_rdy), 32'd0);
      chk("stall_res_y", 32'(res_y), 32'd6);
      chk("stall_res_id", 32'(res_id), 32'd0);
    end
    res_ready = 1'b1;
    step();
    chk("drain_accept_ready", 32'(last_rdy), 32'b0010);
    chk("drain_accept_valid", 32'(res_valid), 32'd1);
    chk("drain_accept_id", 32'(res_id), 32'd1);
    chk("drain_accept_y", 32'(res_y), 32'd20);

    // Reset while holding a result
    rst_n = 1'b0; step();
    chk("midreset_valid", 32'(res_valid), 32'd0);
    chk("midreset_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    step();
    chk("postreset_grant", 32'(last_rdy), 32'b0001);
    req_valid = '0;
    step(); step();

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      req_valid = 4'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      res_ready = 1'($urandom_range(0, 1));
      step();
    end

    req_valid = '0; res_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
